// File: rtl/uart_tx_fifo_if.sv
// Host/serializer side signal bundle for the UART transmit FIFO.
// master drives the strobes and write data, slave is the FIFO itself.
interface uart_tx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  CLR;
   logic                  WR_EN;
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic                  FULL;
   logic                  EMPTY;
   logic [ADDR_WIDTH:0]   COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  ser_en;

   modport master (
      output CLR, WR_EN, WR_DATA, ser_en,
      input  FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW, P_DATA, Data_Valid
   );

   modport slave (
      input  CLR, WR_EN, WR_DATA, ser_en,
      output FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW, P_DATA, Data_Valid
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead transmit byte FIFO feeding the UART TX FSM; the head byte is
// popped on the FSM's ser_en load strobe so consecutive frames run gap-free.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_fifo_if.slave  bus
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [ADDR_WIDTH-1:0]            wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]              count;
   logic                             overflow, underflow;
   logic                             full, empty, wr_acc, pop;

   // Both decisions use registered occupancy only, so Data_Valid never
   // loops back through ser_en and a write at FULL is dropped even on a pop.
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign wr_acc = bus.WR_EN && !full;
   assign pop    = bus.ser_en && !empty;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mem       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.CLR) begin
         // Storage is left as-is; only the bookkeeping is flushed.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            mem[wr_ptr] <= bus.WR_DATA;
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         if (wr_acc && !pop)      count <= count + (ADDR_WIDTH+1)'(1);
         else if (pop && !wr_acc) count <= count - (ADDR_WIDTH+1)'(1);
         if (bus.WR_EN && full)   overflow  <= 1'b1;
         if (bus.ser_en && empty) underflow <= 1'b1;
      end
   end

   assign bus.FULL       = full;
   assign bus.EMPTY      = empty;
   assign bus.COUNT      = count;
   assign bus.OVERFLOW   = overflow;
   assign bus.UNDERFLOW  = underflow;
   assign bus.P_DATA     = mem[rd_ptr];
   assign bus.Data_Valid = !empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue model checked every cycle plus
// literal expectations for each scenario.
module tb_uart_tx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic CLK, RST;
   int   n_chk, n_fail;

   uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO is just an ordered queue of bytes plus two flags.
   logic [DW-1:0] q[$];
   logic          m_ovf, m_und;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q.delete();
         m_ovf <= 1'b0;
         m_und <= 1'b0;
      end else if (bus.CLR) begin
         q.delete();
         m_ovf <= 1'b0;
         m_und <= 1'b0;
      end else begin
         automatic int  sz  = q.size();
         automatic bit  acc = bus.WR_EN && (sz < DEPTH);
         automatic bit  pp  = bus.ser_en && (sz > 0);
         if (bus.WR_EN && sz == DEPTH) m_ovf <= 1'b1;
         if (bus.ser_en && sz == 0)    m_und <= 1'b1;
         if (pp)  void'(q.pop_front());
         if (acc) q.push_back(bus.WR_DATA);
      end
   end

   always @(negedge CLK) begin
      if (RST) begin
         chk("m_count", 32'(bus.COUNT), 32'(q.size()));
         chk("m_empty", 32'(bus.EMPTY), 32'(q.size() == 0));
         chk("m_full",  32'(bus.FULL),  32'(q.size() == DEPTH));
         chk("m_valid", 32'(bus.Data_Valid), 32'(q.size() != 0));
         chk("m_ovf",   32'(bus.OVERFLOW),  32'(m_ovf));
         chk("m_und",   32'(bus.UNDERFLOW), 32'(m_und));
         if (q.size() != 0) chk("m_pdata", 32'(bus.P_DATA), 32'(q[0]));
      end
   end

   // One strobe cycle: drive, clock, then return inputs to idle.
   task automatic cyc(input logic we, input logic [DW-1:0] d, input logic se, input logic clr);
      bus.WR_EN = we; bus.WR_DATA = d; bus.ser_en = se; bus.CLR = clr;
      @(posedge CLK); #1;
      bus.WR_EN = 1'b0; bus.WR_DATA = '0; bus.ser_en = 1'b0; bus.CLR = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp3 [3];
      logic [DW-1:0] prev, nv;
      exp3 = '{8'h11, 8'h22, 8'h33};
      n_chk = 0; n_fail = 0;
      RST = 1'b0;
      bus.WR_EN = 1'b0; bus.WR_DATA = '0; bus.ser_en = 1'b0; bus.CLR = 1'b0;
      #3;
      chk("rst_count", 32'(bus.COUNT), 0);
      chk("rst_empty", 32'(bus.EMPTY), 1);
      chk("rst_full",  32'(bus.FULL), 0);
      chk("rst_valid", 32'(bus.Data_Valid), 0);
      chk("rst_pdata", 32'(bus.P_DATA), 0);
      chk("rst_flags", 32'({bus.OVERFLOW, bus.UNDERFLOW}), 0);
      #9 RST = 1'b1;
      @(posedge CLK); #1;

      // Single byte in and out
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("a5_valid", 32'(bus.Data_Valid), 1);
      chk("a5_pdata", 32'(bus.P_DATA), 32'hA5);
      chk("a5_count", 32'(bus.COUNT), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("a5_pop_valid", 32'(bus.Data_Valid), 0);
      chk("a5_pop_empty", 32'(bus.EMPTY), 1);
      chk("a5_pop_count", 32'(bus.COUNT), 0);

      // Three bytes drained at frame spacing
      for (int i = 0; i < 3; i++) cyc(1'b1, exp3[i], 1'b0, 1'b0);
      chk("f3_count", 32'(bus.COUNT), 3);
      for (int k = 0; k < 3; k++) begin
         chk("f3_pdata", 32'(bus.P_DATA), 32'(exp3[k]));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("f3_count_dec", 32'(bus.COUNT), 32'(2 - k));
         idle(10);
      end
      chk("f3_flags", 32'({bus.OVERFLOW, bus.UNDERFLOW}), 0);

      // Fill, overflow, overflow-with-pop, drain
      for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full",  32'(bus.FULL), 1);
      chk("fill_count", 32'(bus.COUNT), 8);
      chk("fill_ovf0",  32'(bus.OVERFLOW), 0);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovf_flag",  32'(bus.OVERFLOW), 1);
      chk("ovf_count", 32'(bus.COUNT), 8);
      chk("ovf_head",  32'(bus.P_DATA), 1);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("ovfpop_count", 32'(bus.COUNT), 7);
      for (int i = 2; i <= 8; i++) begin
         chk("drain_pdata", 32'(bus.P_DATA), 32'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(bus.EMPTY), 1);

      // Simultaneous write+pop at COUNT=1, across several pointer wraps
      cyc(1'b1, 8'h10, 1'b0, 1'b0);
      prev = 8'h10;
      for (int i = 0; i < 20; i++) begin
         nv = 8'h20 + 8'(i);
         chk("wp_head", 32'(bus.P_DATA), 32'(prev));
         cyc(1'b1, nv, 1'b1, 1'b0);
         chk("wp_count", 32'(bus.COUNT), 1);
         prev = nv;
      end
      chk("wp_last", 32'(bus.P_DATA), 32'h33);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow, then flush with data present and traffic on the same cycle
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("und_flag",  32'(bus.UNDERFLOW), 1);
      chk("und_count", 32'(bus.COUNT), 0);
      chk("und_ovf_sticky", 32'(bus.OVERFLOW), 1);
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("und_ptr", 32'(bus.P_DATA), 32'h3C);
      cyc(1'b1, 8'h77, 1'b1, 1'b1);
      chk("clr_flags", 32'({bus.OVERFLOW, bus.UNDERFLOW}), 0);
      chk("clr_count", 32'(bus.COUNT), 0);
      chk("clr_empty", 32'(bus.EMPTY), 1);

      // Asynchronous reset mid-cycle with five bytes held
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(bus.COUNT), 5);
      #2 RST = 1'b0;
      #1;
      chk("arst_count", 32'(bus.COUNT), 0);
      chk("arst_valid", 32'(bus.Data_Valid), 0);
      chk("arst_pdata", 32'(bus.P_DATA), 0);
      @(negedge CLK); #2 RST = 1'b1;
      @(posedge CLK); #1;
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_pdata", 32'(bus.P_DATA), 32'h5A);
      chk("post_rst_valid", 32'(bus.Data_Valid), 1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer sitting directly upstream of the UART TX control FSM and serializer.
- The host writes bytes at its own pace. The block presents the oldest byte on P_DATA with Data_Valid held high whenever it holds data.
- The byte is popped in the cycle the TX FSM asserts its serializer load strobe (ser_en), so back-to-back frames, including the stop-to-start hand-off, run without gaps.
- Occupancy, full/empty and sticky error flags go to the host.

Parameters:
- DATA_WIDTH, 8, width of each stored byte and of P_DATA.
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- ADDR_WIDTH, log2(DEPTH) = 3, pointer width; internal localparam, not overridable.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous flush; empties the FIFO and clears the sticky flags.
- WR_EN  input  1  host write strobe.
- WR_DATA  input  DATA_WIDTH  host write data.
- FULL  output  1  occupancy == DEPTH.
- EMPTY  output  1  occupancy == 0.
- COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky; a write was dropped.
- UNDERFLOW  output  1  sticky; ser_en arrived while empty.
- P_DATA  output  DATA_WIDTH  head-of-FIFO byte to the serializer.
- Data_Valid  output  1  to TX FSM; equals !EMPTY.
- ser_en  input  1  load strobe from TX FSM; a pop acknowledge.

Behaviour:
- Reset (RST low, async): wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, Data_Valid=0, OVERFLOW=0, UNDERFLOW=0. All storage cleared to 0, so P_DATA=0.
- Storage is a register array. P_DATA = mem[rd_ptr] combinationally from registers (show-ahead). P_DATA is stable for the whole cycle Data_Valid is high.
- Data_Valid = !EMPTY, driven combinationally from registered COUNT; no dependence on ser_en (no combinational loop with the FSM).
- Write accept: WR_EN && !FULL, using FULL as it stands at the start of the cycle. On accept, mem[wr_ptr] <= WR_DATA and wr_ptr increments.
- Write while FULL: the write is dropped, even if a pop occurs in the same cycle. OVERFLOW <= 1. Storage, pointers and COUNT are unchanged by the write.
- Pop: ser_en && Data_Valid. rd_ptr increments, and the next entry appears on P_DATA the following cycle.
- ser_en while EMPTY: no pop, pointers unchanged, UNDERFLOW <= 1.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH roll-over). COUNT tracks occupancy explicitly.
- COUNT update:
  - accept only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Simultaneous write and pop at COUNT=1: the pop takes the old head, the new byte becomes head next cycle, and COUNT stays 1.
- Write into an empty FIFO: Data_Valid rises the cycle after the write (1-cycle latency). P_DATA equals the written byte in that same cycle.
- TX FSM timing: ser_en is asserted in IDLE (with Data_Valid) and in STOP (with Data_Valid). Each ser_en pops exactly one byte. Data_Valid is ignored by the FSM in START/DATA/PARITY, so it may stay high there.
- CLR (sync, overrides all activity in that cycle): pointers and COUNT go to 0, both sticky flags go to 0, and the simultaneous write and pop are discarded. Storage contents are not cleared.
- Reset mid-frame: the FIFO empties immediately (Data_Valid=0 asynchronously). The FSM resets on the same RST, so no partial pop can occur.
- No arithmetic beyond pointer and count increment/decrement. COUNT never exceeds DEPTH or goes below 0.

Test Plan:
- Reset then write 0xA5 -> next cycle Data_Valid=1, P_DATA=0xA5, COUNT=1; ser_en pulse -> next cycle Data_Valid=0, EMPTY=1, COUNT=0.
- Write 0x11,0x22,0x33 back-to-back, then pop with three ser_en pulses spaced 11 cycles apart (frame period) -> P_DATA sequence 0x11, 0x22, 0x33 in order; COUNT 3→2→1→0; no flags set.
- Fill 8 entries (0x01..0x08), then write 0xFF -> FULL=1, OVERFLOW=1, COUNT=8. Drain all 8 -> outputs 0x01..0x08 and 0xFF never appears.
- COUNT=1 (head 0x10): same cycle WR_EN with 0x20 and ser_en -> COUNT stays 1, next P_DATA=0x20; repeat 20 times across pointer wrap with no corruption.
- ser_en pulse while EMPTY -> UNDERFLOW=1, COUNT=0, pointers unchanged. Then assert CLR -> UNDERFLOW=0, OVERFLOW=0.
- COUNT=5, drop RST asynchronously mid-cycle -> immediately COUNT=0, Data_Valid=0, P_DATA=0x00. Release, write 0x5A -> P_DATA=0x5A next cycle.
